pipe_skid_reg: RTL
==================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 96: payload width in bits (decoded ID->EX bundle).
REQ-002 SHALL have parameter BUBBLE, default {WIDTH{1'b0}}: payload driven when no valid entry (NOP encoding).
REQ-003 SHALL have parameter CNT_W, default 16: bubble counter width.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-low reset.
REQ-007 flush  input  1  discard all held and incoming entries (branch mispredict).
REQ-008 in_valid  input  1  upstream offers in_data.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 in_data  input  WIDTH  upstream payload.
REQ-011 out_valid  output  1  out_data holds a valid entry.
REQ-012 out_ready  input  1  downstream consumes out_data this cycle.
REQ-013 out_data  output  WIDTH  head payload, or BUBBLE when out_valid=0.
REQ-014 bubble_cnt  output  CNT_W  count of bubbles delivered downstream.

Function
REQ-015 Accept SHALL occur when in_valid=1 and in_ready=1; pop SHALL occur when out_valid=1 and out_ready=1.
REQ-016 Storage SHALL be a main register (head) plus a skid register; occupancy states EMPTY, ONE, FULL.
REQ-017 out_valid SHALL be 1 in ONE and FULL; out_data SHALL be main when out_valid=1, else BUBBLE.
REQ-018 in_ready SHALL be registered: 1 in EMPTY and ONE, 0 in FULL; no combinational path out_ready->in_ready.
REQ-019 EMPTY: accept -> ONE, main<=in_data; else stay.
REQ-020 ONE: accept+pop -> ONE, main<=in_data; accept only -> FULL, skid<=in_data; pop only -> EMPTY; neither -> stay.
REQ-021 FULL: pop -> ONE, main<=skid; no pop -> stay (no accept possible).
REQ-022 Latency in->out SHALL be exactly 1 cycle when EMPTY; sustained throughput 1 entry/cycle with out_ready=1.
REQ-023 Entries SHALL leave in acceptance order; none lost or duplicated.
REQ-024 flush=1 SHALL force EMPTY next cycle, discarding main, skid and any same-cycle input; a same-cycle pop still counts as consumed downstream.
REQ-025 bubble_cnt SHALL increment when out_ready=1 and out_valid=0, saturate at all-ones, and not be cleared by flush.
REQ-026 Held data SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-027 rst=0 at a rising edge SHALL set state EMPTY, main and skid to BUBBLE, bubble_cnt to 0, in_ready to 1; inputs ignored that cycle.
REQ-028 Reset SHALL override flush and any handshake in the same cycle, including mid-FULL.
REQ-029 Outputs after reset: out_valid=0, out_data=BUBBLE, in_ready=1, bubble_cnt=0.

Configuration
REQ-030 Macro PIPE_SKID_REG_SKID_EN SHALL select the skid variant.
REQ-031 With PIPE_SKID_REG_SKID_EN defined: two-entry behaviour of REQ-016..REQ-021, registered in_ready.
REQ-032 Without it: skid register and FULL state SHALL not exist; in_ready SHALL equal (!out_valid || out_ready) combinationally; EMPTY/ONE transitions per REQ-019/REQ-020 with accept-only in ONE impossible; all other requirements unchanged.

Verification (WIDTH=8, BUBBLE=8'h13, CNT_W=4)
REQ-033 Reset, then in_valid=1 in_data=8'hA1 out_ready=1 -> next cycle out_valid=1 out_data=8'hA1; following cycle out_valid=0 out_data=8'h13.
REQ-034 out_ready=0, send 8'h01,8'h02 (skid) -> in_ready=0 after second accept; out_ready=1 -> outputs 8'h01 then 8'h02, in_ready returns 1.
REQ-035 FULL with 8'h05/8'h06, assert flush with in_valid=1 in_data=8'h07 -> next cycle out_valid=0, in_ready=1; 8'h07 never appears.
REQ-036 Hold out_valid=0, out_ready=1 for 20 cycles -> bubble_cnt=4'hF, stays; flush leaves it 4'hF; rst=0 clears to 0.
REQ-037 Stream 8'h10..8'h1F with random out_ready (seeded) -> output sequence identical to input, no gaps while both sides ready, out_data stable under backpressure.
REQ-038 Assert rst=0 while FULL and out_ready=1 -> next cycle out_valid=0, out_data=8'h13, in_ready=1, bubble_cnt=0.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//   One-stage pipeline register for the decoded ID->EX bundle, with an
//   optional second (skid) entry so that in_ready can be registered and does
//   not depend combinationally on out_ready.
//
//   Build option:
//     PIPE_SKID_REG_SKID_EN  defined   -> two-entry skid buffer (EMPTY/ONE/FULL),
//                                         in_ready is a flop.
//                            undefined -> single register (EMPTY/ONE),
//                                         in_ready = !out_valid || out_ready.
//
//   Parameters:
//     WIDTH   payload width in bits
//     BUBBLE  payload shown on out_data when no valid entry (NOP encoding)
//     CNT_W   width of the saturating bubble counter
//
//   Ports:
//     clk         clock, all state changes on rising edge
//     rst         synchronous active-low reset
//     flush       drop held entries and any same-cycle input
//     in_valid    upstream offers in_data
//     in_ready    block accepts in_data this cycle
//     in_data     upstream payload
//     out_valid   out_data holds a valid entry
//     out_ready   downstream consumes out_data this cycle
//     out_data    head payload, or BUBBLE when out_valid=0
//     bubble_cnt  saturating count of cycles downstream was ready but got nothing
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
   parameter int               WIDTH  = 96,
   parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
   parameter int               CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] bubble_cnt
);

`ifdef PIPE_SKID_REG_SKID_EN
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;
`else
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_ONE   = 1'b1
   } state_t;
`endif

   state_t           state_q, state_nxt;
   logic [WIDTH-1:0] main_q,  main_nxt;
   logic [CNT_W-1:0] bubble_cnt_q;
   logic             accept;
   logic             pop;

`ifdef PIPE_SKID_REG_SKID_EN
   logic [WIDTH-1:0] skid_q, skid_nxt;
   logic             in_ready_q;

   // in_ready is a flop loaded from the next state, so out_ready never
   // reaches in_ready through logic.
   assign in_ready = in_ready_q;
`else
   assign in_ready = !out_valid || out_ready;
`endif

   assign out_valid  = (state_q != ST_EMPTY);
   assign out_data   = out_valid ? main_q : BUBBLE;
   assign bubble_cnt = bubble_cnt_q;

   assign accept = in_valid  && in_ready;
   assign pop    = out_valid && out_ready;

   // ---------------------------------------------------------------------------
   // Next-state / next-data logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a value unassigned and no latch is inferred.
      state_nxt = state_q;
      main_nxt  = main_q;
`ifdef PIPE_SKID_REG_SKID_EN
      skid_nxt  = skid_q;
`endif

      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_nxt = ST_ONE;
               main_nxt  = in_data;
            end
         end

         ST_ONE: begin
            if (accept && pop) begin
               main_nxt = in_data;
`ifdef PIPE_SKID_REG_SKID_EN
            end else if (accept) begin
               // Head is stalled: park the new entry behind it.
               state_nxt = ST_FULL;
               skid_nxt  = in_data;
`else
            end else if (accept) begin
               // Unreachable here: in ONE, accept implies out_ready, hence pop.
               main_nxt = in_data;
`endif
            end else if (pop) begin
               state_nxt = ST_EMPTY;
            end
         end

`ifdef PIPE_SKID_REG_SKID_EN
         ST_FULL: begin
            if (pop) begin
               state_nxt = ST_ONE;
               main_nxt  = skid_q;
            end
         end
`endif

         default: state_nxt = ST_EMPTY;
      endcase

      // Mispredict: everything held or arriving this cycle is dropped.
      if (flush) begin
         state_nxt = ST_EMPTY;
      end
   end

   // ---------------------------------------------------------------------------
   // State and payload registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!rst) begin
         state_q <= ST_EMPTY;
         // NOTE: the two payload registers are ordinary flops, not a RAM, so
         // they are reset to BUBBLE and never hold X after reset.
         main_q  <= BUBBLE;
`ifdef PIPE_SKID_REG_SKID_EN
         skid_q     <= BUBBLE;
         in_ready_q <= 1'b1;
`endif
      end else begin
         state_q <= state_nxt;
         main_q  <= main_nxt;
`ifdef PIPE_SKID_REG_SKID_EN
         skid_q     <= skid_nxt;
         in_ready_q <= (state_nxt != ST_FULL);
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Bubble counter: downstream was ready but nothing was offered.
   // Saturates at all-ones; flush deliberately does not clear it.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         bubble_cnt_q <= '0;
      end else if (out_ready && !out_valid && (bubble_cnt_q != {CNT_W{1'b1}})) begin
         bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
   end

endmodule
